// File: rtl/bubsysrom_pkg.sv
// Shared types and default geometry for the BUBSYSROM colour RAM CPU interface.
package bubsysrom_pkg;

  localparam int AW_DEF = 11;
  localparam int DW_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_ACK     = 3'd4
  } state_e;

endpackage

// File: rtl/bubsysrom_colorram_cpuif.sv
// 68000 access port onto the colour RAM: CPU cycles are slotted into 6 MHz
// negative-phase enables (or any cycle while blanking) and acknowledged via DTACK.
module bubsysrom_colorram_cpuif
  import bubsysrom_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          i_EMU_MCLK,
  input  logic          i_EMU_RST,
  input  logic          i_EMU_CLK6MNCEN_n,
  input  logic          i_BLK,
  input  logic [AW-1:0] i_CD,
  input  logic          i_CPU_AS_n,
  input  logic          i_COLORRAM_n,
  input  logic [AW-1:0] i_CPU_ADDR,
  input  logic          i_CPU_RW,
  input  logic          i_CPU_UDS_n,
  input  logic          i_CPU_LDS_n,
  input  logic [DW-1:0] i_CPU_DIN,
  output logic [DW-1:0] o_CPU_DOUT,
  output logic          o_CPU_DTACK_n,
  output logic [AW-1:0] o_RAM_ADDR,
  output logic [DW-1:0] o_RAM_DIN,
  output logic          o_RAM_WRH_n,
  output logic          o_RAM_WRL_n,
  input  logic [DW-1:0] i_RAM_DOUT
);

  state_e        state_q, state_d;
  logic          dtack_n_q, dtack_n_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          req_s, slot_s;
  logic [AW-1:0] ram_addr_s;
  logic          ram_wrh_n_s, ram_wrl_n_s;

  assign req_s  = !i_CPU_AS_n && !i_COLORRAM_n && (!i_CPU_UDS_n || !i_CPU_LDS_n);
  assign slot_s = !i_EMU_CLK6MNCEN_n || !i_BLK;

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s && slot_s) begin
          state_d = ST_ACCESS;
        end else if (req_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      // A dropped request wins over a slot arriving in the same cycle.
      ST_WAIT: begin
        if (!req_s) begin
          state_d = ST_IDLE;
        end else if (slot_s) begin
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_ACCESS: begin
        if (i_CPU_RW) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_CAPTURE: state_d = ST_ACK;
      ST_ACK: begin
        if (i_CPU_AS_n) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write strobes are gated by reset so an aborted ACCESS never commits a write.
  always_comb begin
    ram_addr_s  = i_CD;
    ram_wrh_n_s = 1'b1;
    ram_wrl_n_s = 1'b1;
    dout_d      = dout_q;
    dtack_n_d   = (state_d == ST_ACK) ? 1'b0 : 1'b1;
    if (state_q == ST_ACCESS) begin
      ram_addr_s = i_CPU_ADDR;
      if (!i_CPU_RW && !i_EMU_RST) begin
        ram_wrh_n_s = i_CPU_UDS_n;
        ram_wrl_n_s = i_CPU_LDS_n;
      end else begin
        ram_wrh_n_s = 1'b1;
        ram_wrl_n_s = 1'b1;
      end
    end else if (state_q == ST_CAPTURE) begin
      dout_d = i_RAM_DOUT;
    end else begin
      dout_d = dout_q;
    end
  end

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_RST) begin
      dtack_n_q <= 1'b1;
      dout_q    <= '0;
    end else begin
      dtack_n_q <= dtack_n_d;
      dout_q    <= dout_d;
    end
  end

  assign o_CPU_DTACK_n = dtack_n_q;
  assign o_CPU_DOUT    = dout_q;
  assign o_RAM_ADDR    = ram_addr_s;
  assign o_RAM_DIN     = i_CPU_DIN;
  assign o_RAM_WRH_n   = ram_wrh_n_s;
  assign o_RAM_WRL_n   = ram_wrl_n_s;

endmodule

// File: tb/tb_bubsysrom_colorram_cpuif.sv
// Scoreboard bench for the colour RAM CPU interface: a driver issues CPU bus
// cycles and queues expected responses; a monitor checks DTACK, writes and addressing.
module tb_bubsysrom_colorram_cpuif;

  localparam int AW = 11;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen_n = 1'b1;
  logic          blk = 1'b1;
  logic          as_n = 1'b1;
  logic          colorram_n = 1'b1;
  logic          rw = 1'b1;
  logic          uds_n = 1'b1;
  logic          lds_n = 1'b1;
  logic [AW-1:0] cd = '0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          dtack_n;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          wrh_n, wrl_n;
  logic [DW-1:0] ram_dout;

  typedef struct {
    int            t0;
    int            lat;
    bit            rd;
    logic [DW-1:0] data;
  } rsp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wrh_n;
    logic          wrl_n;
    logic [DW-1:0] data;
  } wr_t;

  rsp_t     rq[$];
  wr_t      wq[$];
  bit [DW-1:0] ram  [0:(1<<AW)-1];
  bit [DW-1:0] mref [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;
  int acc_cnt = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  bubsysrom_colorram_cpuif #(.AW(AW), .DW(DW)) dut (
    .i_EMU_MCLK       (clk),
    .i_EMU_RST        (rst),
    .i_EMU_CLK6MNCEN_n(cen_n),
    .i_BLK            (blk),
    .i_CD             (cd),
    .i_CPU_AS_n       (as_n),
    .i_COLORRAM_n     (colorram_n),
    .i_CPU_ADDR       (cpu_addr),
    .i_CPU_RW         (rw),
    .i_CPU_UDS_n      (uds_n),
    .i_CPU_LDS_n      (lds_n),
    .i_CPU_DIN        (din),
    .o_CPU_DOUT       (dout),
    .o_CPU_DTACK_n    (dtack_n),
    .o_RAM_ADDR       (ram_addr),
    .o_RAM_DIN        (ram_din),
    .o_RAM_WRH_n      (wrh_n),
    .o_RAM_WRL_n      (wrl_n),
    .i_RAM_DOUT       (ram_dout)
  );

  // External colour RAM: byte-lane writes, 1-cycle synchronous read.
  always @(posedge clk) begin
    ram_dout <= ram[ram_addr];
    if (!wrh_n) ram[ram_addr][15:8] <= ram_din[15:8];
    if (!wrl_n) ram[ram_addr][7:0]  <= ram_din[7:0];
  end

  initial forever begin
    @(posedge clk);
    edge_cnt = edge_cnt + 1;
  end

  // Video address always differs from the CPU address so ACCESS cycles are visible.
  initial forever begin
    @(posedge clk);
    #2;
    cd = cpu_addr ^ AW'($urandom_range(1, (1<<AW)-1));
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp = n_cmp + 1;
    n_err = n_err + 1;
    $display("FAIL %s: event seen, none expected", nm);
  endtask

  // Monitor: every access cycle, write pulse and DTACK fall is matched to the scoreboard.
  initial begin
    rsp_t r;
    wr_t  e;
    logic dtack_prev;
    dtack_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (ram_addr !== cd) begin
          acc_cnt = acc_cnt + 1;
          chk("access_addr", 32'(ram_addr), 32'(cpu_addr));
        end
        if (!wrh_n || !wrl_n) begin
          if (wq.size() == 0) begin
            flag("unexpected_write");
          end else begin
            e = wq.pop_front();
            chk("wr_addr", 32'(ram_addr), 32'(e.addr));
            chk("wr_lanes", 32'({wrh_n, wrl_n}), 32'({e.wrh_n, e.wrl_n}));
            chk("wr_data", 32'(ram_din), 32'(e.data));
          end
        end
        if (dtack_prev && !dtack_n) begin
          if (rq.size() == 0) begin
            flag("unexpected_dtack");
          end else begin
            r = rq.pop_front();
            chk("dtack_latency", 32'(edge_cnt - r.t0), 32'(r.lat));
            chk("access_cycles", 32'(acc_cnt), 32'd1);
            if (r.rd) chk("read_data", 32'(dout), 32'(r.data));
          end
          acc_cnt = 0;
        end
        dtack_prev = dtack_n;
      end
    end
  end

  task automatic set_slot(input int i, input int w, input bit use_blk);
    if (i < w) begin
      blk = 1'b1; cen_n = 1'b1;
    end else if (i == w) begin
      if (use_blk) begin
        blk = 1'b0; cen_n = 1'($urandom_range(0, 1));
      end else begin
        blk = 1'b1; cen_n = 1'b0;
      end
    end else begin
      blk = 1'($urandom_range(0, 1)); cen_n = 1'($urandom_range(0, 1));
    end
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase.
  task automatic do_cycle(input bit rd, input logic [AW-1:0] a, input bit u_n, input bit l_n,
                          input logic [DW-1:0] d, input int w, input bit use_blk,
                          input int hold, input bit rst_in_ack);
    rsp_t r;
    wr_t  e;
    bit   got;
    int   i;
    as_n = 1'b0; colorram_n = 1'b0; rw = rd; uds_n = u_n; lds_n = l_n;
    cpu_addr = a; din = d;
    set_slot(0, w, use_blk);
    r.t0 = edge_cnt; r.lat = w + (rd ? 3 : 2); r.rd = rd; r.data = mref[a];
    rq.push_back(r);
    if (!rd) begin
      e.addr = a; e.wrh_n = u_n; e.wrl_n = l_n; e.data = d;
      wq.push_back(e);
      if (!u_n) mref[a][15:8] = d[15:8];
      if (!l_n) mref[a][7:0]  = d[7:0];
    end
    got = 1'b0;
    i = 0;
    while (!got && i < 40) begin
      @(negedge clk);
      if (dtack_n == 1'b0) got = 1'b1;
      @(posedge clk); #1;
      i = i + 1;
      set_slot(i, w, use_blk);
    end
    if (!got) begin
      chk("dtack_timeout", 32'(dtack_n), 32'd0);
      rq.delete();
      wq.delete();
    end
    if (rst_in_ack) begin
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_ack_dtack", 32'(dtack_n), 32'd1);
      chk("rst_ack_dout", 32'(dout), 32'd0);
      chk("rst_ack_we", 32'({wrh_n, wrl_n}), 32'd3);
      chk("rst_ack_addr", 32'(ram_addr), 32'(cd));
      rst = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
      @(posedge clk); #1;
    end else begin
      repeat (hold) begin @(posedge clk); #1; end
      as_n = 1'b1; colorram_n = 1'($urandom_range(0, 1)); uds_n = 1'b1; lds_n = 1'b1;
      @(posedge clk); #1;
      chk("ack_release", 32'(dtack_n), 32'd1);
    end
  endtask

  task automatic do_abort(input logic [AW-1:0] a, input int drop_after);
    as_n = 1'b0; colorram_n = 1'b0; rw = 1'($urandom_range(0, 1));
    uds_n = 1'b0; lds_n = 1'b0; cpu_addr = a; din = 16'($urandom);
    blk = 1'b1; cen_n = 1'b1;
    repeat (drop_after) begin @(posedge clk); #1; end
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_dtack", 32'(dtack_n), 32'd1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    bit rd;
    logic [AW-1:0] a;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_dtack", 32'(dtack_n), 32'd1);
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_we", 32'({wrh_n, wrl_n}), 32'd3);
    chk("reset_addr", 32'(ram_addr), 32'(cd));
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    do_cycle(1'b0, 11'h123, 1'b0, 1'b0, 16'h7C1F, 0, 1'b1, 0, 1'b0);
    chk("blank_write_ram", 32'(ram[11'h123]), 32'h7C1F);
    do_cycle(1'b1, 11'h123, 1'b0, 1'b0, 16'h0000, 3, 1'b0, 1, 1'b0);
    chk("slotted_read_dout", 32'(dout), 32'h7C1F);
    do_cycle(1'b0, 11'h123, 1'b1, 1'b0, 16'h00AA, 0, 1'b1, 0, 1'b0);
    chk("lds_write_ram", 32'(ram[11'h123]), 32'h7CAA);
    do_abort(11'h123, 2);
    chk("abort_ram", 32'(ram[11'h123]), 32'h7CAA);
    do_cycle(1'b0, 11'h050, 1'b0, 1'b0, 16'h1234, 1, 1'b0, 0, 1'b0);
    do_cycle(1'b0, 11'h051, 1'b0, 1'b0, 16'hBEEF, 0, 1'b0, 0, 1'b0);
    do_cycle(1'b1, 11'h123, 1'b0, 1'b1, 16'h0000, 0, 1'b1, 0, 1'b1);
    @(posedge clk); #1;

    for (int k = 0; k < 40; k++) begin
      a = AW'(11'h120 + AW'($urandom_range(0, 7)));
      if ($urandom_range(0, 9) == 0) begin
        do_abort(a, 1 + $urandom_range(0, 2));
      end else begin
        rd = 1'($urandom_range(0, 1));
        s  = $urandom_range(0, 2);
        do_cycle(rd, a, (s == 1) ? 1'b0 : (s == 2) ? 1'b1 : 1'b0,
                 (s == 1) ? 1'b1 : 1'b0, 16'($urandom),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2), 1'b0);
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (4) begin @(posedge clk); #1; end
    chk("rsp_queue_drained", 32'(rq.size()), 32'd0);
    chk("wr_queue_drained", 32'(wq.size()), 32'd0);
    chk("stray_access", 32'(acc_cnt), 32'd0);
    for (int k = 0; k < 8; k++) begin
      chk("ram_vs_model", 32'(ram[11'h120 + k]), 32'(mref[11'h120 + k]));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
